ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), to the keyboard over the same ps2_clk/ps2_data pair used by the keyboard receiver. It drives both lines open-drain through output-enable signals and asserts busy so the receiver path ignores the frame. It sits beside ps2_keyboard in top.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_sync_edge.sv | 32 +++
 rtl/ps2_host_tx.sv | 208 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and receiver paths.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        START     = 3'd2,
        SHIFT     = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_state_e;

    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NACK    = 2'b10;
    localparam int         FRAME_BITS  = 10;
    localparam int         MAX_RETRY   = 2;

    // Frame shifted out LSB first after the start bit: data, odd parity, stop.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a raw PS/2 pin with a falling-edge pulse.
module ps2_sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_in,
    output logic level,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Resets to the idle bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= pin_in;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign level = r_sync;
    assign fall  = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain output enables.
// Optional macro PS2_TX_RETRY_EN: silently retry a failed transfer up to MAX_RETRY times.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES    = 5000,
    parameter int START_HOLD_CYCLES = 10,
    parameter int TIMEOUT_CYCLES    = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code
);

    ps2_state_e                r_state;
    logic [FRAME_BITS-1:0]     r_frame;
    logic [3:0]                r_bit_cnt;
    logic [31:0]               r_cnt;
    logic [31:0]               r_to_cnt;
    logic                      r_tx_ready;
    logic                      r_busy;
    logic                      r_clk_oe;
    logic                      r_data_oe;
    logic                      r_done;
    logic                      r_error;
    logic [1:0]                r_err_code;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]                r_retry;
`endif

    logic w_clk_lvl;
    logic w_clk_fall;
    logic w_data_lvl;
    logic w_data_fall_unused;
    logic w_to_active;
    logic w_timeout;
    logic w_nack;

    ps2_sync_edge #(.RST_VAL(1'b1)) u_clk_sync (
        .clk    (clk),
        .rst    (rst),
        .pin_in (ps2_clk_in),
        .level  (w_clk_lvl),
        .fall   (w_clk_fall)
    );

    ps2_sync_edge #(.RST_VAL(1'b1)) u_data_sync (
        .clk    (clk),
        .rst    (rst),
        .pin_in (ps2_data_in),
        .level  (w_data_lvl),
        .fall   (w_data_fall_unused)
    );

    // A device edge always wins over a timeout expiring in the same cycle.
    assign w_to_active = (r_state == SHIFT) || (r_state == ACK) || (r_state == WAIT_IDLE);
    assign w_timeout   = w_to_active && !w_clk_fall && (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign w_nack      = (r_state == ACK) && w_clk_fall && w_data_lvl;

    // Transfer sequencer; every output is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_frame    <= '0;
            r_bit_cnt  <= 4'd0;
            r_cnt      <= 32'd0;
            r_to_cnt   <= 32'd0;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= 2'b00;
`ifdef PS2_TX_RETRY_EN
            r_retry    <= 2'd0;
`endif
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            if (w_timeout || w_nack) begin
`ifdef PS2_TX_RETRY_EN
                if (r_retry < 2'(MAX_RETRY)) begin
                    r_retry   <= r_retry + 2'd1;
                    r_state   <= INHIBIT;
                    r_cnt     <= 32'd0;
                    r_clk_oe  <= 1'b1;
                    r_data_oe <= 1'b0;
                end else begin
                    r_state    <= IDLE;
                    r_tx_ready <= 1'b1;
                    r_busy     <= 1'b0;
                    r_clk_oe   <= 1'b0;
                    r_data_oe  <= 1'b0;
                    r_error    <= 1'b1;
                    r_err_code <= w_nack ? ERR_NACK : ERR_TIMEOUT;
                end
`else
                r_state    <= IDLE;
                r_tx_ready <= 1'b1;
                r_busy     <= 1'b0;
                r_clk_oe   <= 1'b0;
                r_data_oe  <= 1'b0;
                r_error    <= 1'b1;
                r_err_code <= w_nack ? ERR_NACK : ERR_TIMEOUT;
`endif
            end else begin
                case (r_state)
                    IDLE: begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        if (tx_valid && r_tx_ready) begin
                            r_frame    <= build_frame(tx_data);
                            r_cnt      <= 32'd0;
                            r_clk_oe   <= 1'b1;
                            r_tx_ready <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
                            r_retry    <= 2'd0;
`endif
                        end
                    end
                    INHIBIT: begin
                        if (r_cnt == 32'(INHIBIT_CYCLES - 1)) begin
                            r_cnt     <= 32'd0;
                            r_data_oe <= 1'b1;
                            r_state   <= START;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    START: begin
                        if (r_cnt == 32'(START_HOLD_CYCLES - 1)) begin
                            r_cnt     <= 32'd0;
                            r_clk_oe  <= 1'b0;
                            r_bit_cnt <= 4'd0;
                            r_to_cnt  <= 32'd0;
                            r_state   <= SHIFT;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    SHIFT: begin
                        if (w_clk_fall) begin
                            r_to_cnt  <= 32'd0;
                            r_data_oe <= ~r_frame[r_bit_cnt];
                            if (r_bit_cnt == 4'(FRAME_BITS - 1)) begin
                                r_bit_cnt <= 4'd0;
                                r_state   <= ACK;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end else begin
                            r_to_cnt <= r_to_cnt + 32'd1;
                        end
                    end
                    ACK: begin
                        if (w_clk_fall) begin
                            r_to_cnt <= 32'd0;
                            r_state  <= WAIT_IDLE;
                        end else begin
                            r_to_cnt <= r_to_cnt + 32'd1;
                        end
                    end
                    WAIT_IDLE: begin
                        if (w_clk_lvl && w_data_lvl) begin
                            r_done     <= 1'b1;
                            r_tx_ready <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= IDLE;
                        end else if (w_clk_fall) begin
                            r_to_cnt <= 32'd0;
                        end else begin
                            r_to_cnt <= r_to_cnt + 32'd1;
                        end
                    end
                    default: begin
                        r_state    <= IDLE;
                        r_tx_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_clk_oe   <= 1'b0;
                        r_data_oe  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_ready    = r_tx_ready;
    assign busy        = r_busy;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign done        = r_done;
    assign error       = r_error;
    assign err_code    = r_err_code;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: behavioural PS/2 device, bit scoreboard and vector table.
module tb_ps2_host_tx;

    localparam int INH = 60;
    localparam int SH  = 10;
    localparam int TO  = 3000;
    localparam int LOW = 20;
    localparam int HIGH = 20;
`ifdef PS2_TX_RETRY_EN
    localparam int FAIL_ATTEMPTS = 3;
`else
    localparam int FAIL_ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, error;
    logic [1:0] err_code;
    logic       ps2_clk_in, ps2_data_in;

    assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
    assign ps2_data_in = ~ps2_data_oe & dev_data;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_HOLD_CYCLES(SH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe), .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [2:0] nack_mask;
        int         attempts;
        bit         exp_err;
        logic [1:0] exp_code;
    } vec_t;

    typedef struct {
        bit         done;
        bit         err;
        logic [1:0] code;
        int         attempts;
    } res_t;

    logic bit_q[$];
    res_t res_q[$];
    int checks = 0, errors = 0;
    int cyc = 0;
    int n_done = 0, n_error = 0, n_both = 0, n_acc = 0;
    int n_inh = 0, inh_run = 0, last_inh = 0, st_run = 0, last_st = 0;
    int err_cyc = 0, t_fall = 0;
    logic [1:0] err_oe = 2'b00;
    logic       err_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor sampled on the inactive edge.
    always @(negedge clk) begin
        if (done) n_done++;
        if (done && error) n_both++;
        if (tx_valid && tx_ready && !rst) n_acc++;
        if (error) begin
            n_error++;
            err_cyc = cyc;
            err_oe  = {ps2_clk_oe, ps2_data_oe};
            err_rdy = tx_ready;
        end
        if (ps2_clk_oe && !ps2_data_oe) inh_run++;
        else if (inh_run != 0) begin last_inh = inh_run; n_inh++; inh_run = 0; end
        if (ps2_clk_oe && ps2_data_oe) st_run++;
        else if (st_run != 0) begin last_st = st_run; st_run = 0; end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Expected line levels seen by the device: start, data LSB first, odd parity, stop.
    task automatic push_bits(input logic [7:0] d);
        int ones;
        ones = 0;
        bit_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            bit_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        bit_q.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
        bit_q.push_back(1'b1);
    endtask

    task automatic wait_accept();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (tx_ready) begin got = 1'b1; break; end
        end
        if (!got) begin checks++; errors++; $display("FAIL accept_wait tx_ready never rose"); end
        @(posedge clk); #1;
    endtask

    task automatic dev_transfer(input bit nack, input int stop_after);
        bit got;
        logic b;
        got = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (!ps2_clk_oe && ps2_data_oe) begin got = 1'b1; break; end
        end
        if (!got) begin checks++; errors++; $display("FAIL dev_start no start bit seen"); return; end
        tick(5);
        for (int i = 0; i < 11; i++) begin
            if (bit_q.size() == 0) begin
                checks++; errors++; $display("FAIL frame_bit%0d scoreboard empty", i);
            end else begin
                b = bit_q.pop_front();
                chk($sformatf("frame_bit%0d", i), 32'(ps2_data_in), 32'(b));
            end
            if (i == 10 && !nack) dev_data = 1'b0;
            tick(2);
            dev_clk = 1'b0;
            t_fall  = cyc;
            tick(LOW);
            dev_clk = 1'b1;
            tick(HIGH);
            if (stop_after == i + 1) return;
        end
        tick(3);
        dev_data = 1'b1;
    endtask

    task automatic wait_result(input int d0, input int e0);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (n_done != d0 || n_error != e0) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (!got) begin checks++; errors++; $display("FAIL result_wait no done or error"); end
        tick(2);
    endtask

    task automatic run_vector(input vec_t v);
        int d0, e0, i0;
        res_t r;
        d0 = n_done; e0 = n_error; i0 = n_inh;
        r.done = !v.exp_err; r.err = v.exp_err; r.code = v.exp_code; r.attempts = v.attempts;
        res_q.push_back(r);
        tx_data = v.data; tx_valid = 1'b1;
        wait_accept();
        tx_valid = 1'b0;
        push_bits(v.data);
        for (int a = 0; a < v.attempts; a++) begin
            if (a > 0) push_bits(v.data);
            dev_transfer(v.nack_mask[a], 0);
        end
        wait_result(d0, e0);
        r = res_q.pop_front();
        chk($sformatf("inhibit_len_%0h", v.data), last_inh, INH);
        chk($sformatf("start_len_%0h", v.data), last_st, SH);
        chk($sformatf("inhibit_phases_%0h", v.data), n_inh - i0, r.attempts);
        chk($sformatf("done_count_%0h", v.data), n_done - d0, 32'(r.done));
        chk($sformatf("error_count_%0h", v.data), n_error - e0, 32'(r.err));
        chk($sformatf("err_code_%0h", v.data), err_code, r.code);
        chk($sformatf("busy_after_%0h", v.data), busy, 0);
        chk($sformatf("tx_ready_after_%0h", v.data), tx_ready, 1);
        chk("done_error_overlap", n_both, 0);
        if (r.err) begin
            chk($sformatf("err_oe_%0h", v.data), err_oe, 0);
            chk($sformatf("err_ready_%0h", v.data), err_rdy, 1);
        end
    endtask

    vec_t vecs[5];

    initial begin
        int d0, e0, a0, diff;
        bit got;
        vecs[0] = '{data: 8'hED, nack_mask: 3'b000, attempts: 1, exp_err: 1'b0, exp_code: 2'b00};
        vecs[1] = '{data: 8'h01, nack_mask: 3'b000, attempts: 1, exp_err: 1'b0, exp_code: 2'b00};
        vecs[2] = '{data: 8'hFF, nack_mask: 3'b111, attempts: FAIL_ATTEMPTS, exp_err: 1'b1, exp_code: 2'b10};
        vecs[3] = '{data: 8'h55, nack_mask: 3'b000, attempts: 1, exp_err: 1'b0, exp_code: 2'b10};
        vecs[4] = '{data: 8'h00, nack_mask: 3'b000, attempts: 1, exp_err: 1'b0, exp_code: 2'b10};

        rst = 1'b1;
        tick(4);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_code", err_code, 0);
        rst = 1'b0;
        tick(4);

        for (int i = 0; i < 5; i++) run_vector(vecs[i]);

        // tx_valid held high while busy with changing data
        d0 = n_done; a0 = n_acc;
        tx_data = 8'hED; tx_valid = 1'b1;
        wait_accept();
        push_bits(8'hED);
        tx_data = 8'h55;
        dev_transfer(1'b0, 0);
        wait_accept();
        tx_valid = 1'b0;
        push_bits(8'h55);
        dev_transfer(1'b0, 0);
        wait_result(d0 + 1, n_error);
        chk("held_valid_done", n_done - d0, 2);
        chk("held_valid_accepts", n_acc - a0, 2);

`ifndef PS2_TX_RETRY_EN
        // device stops clocking after four falling edges
        d0 = n_done; e0 = n_error;
        tx_data = 8'hA5; tx_valid = 1'b1;
        wait_accept();
        tx_valid = 1'b0;
        push_bits(8'hA5);
        dev_transfer(1'b0, 4);
        got = 1'b0;
        for (int k = 0; k < TO + 100; k++) begin
            if (n_error != e0) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (!got) begin checks++; errors++; $display("FAIL timeout_wait no error pulse"); end
        diff = err_cyc - t_fall;
        checks++;
        if (!(diff >= TO && diff <= TO + 4)) begin
            errors++;
            $display("FAIL timeout_latency actual=%0d expected=%0d..%0d", diff, TO, TO + 4);
        end
        chk("timeout_err_code", err_code, 2'b01);
        chk("timeout_oe", err_oe, 0);
        chk("timeout_done", n_done - d0, 0);
        bit_q.delete();
        tick(5);
`endif

        // reset in the middle of SHIFT
        d0 = n_done; e0 = n_error;
        tx_data = 8'h3C; tx_valid = 1'b1;
        wait_accept();
        tx_valid = 1'b0;
        push_bits(8'h3C);
        dev_transfer(1'b0, 3);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("mid_rst_ready", tx_ready, 1);
        chk("mid_rst_busy", busy, 0);
        rst = 1'b0;
        tick(10);
        chk("mid_rst_no_done", n_done - d0, 0);
        chk("mid_rst_no_error", n_error - e0, 0);
        bit_q.delete();

`ifdef PS2_TX_RETRY_EN
        run_vector('{data: 8'h96, nack_mask: 3'b011, attempts: 3, exp_err: 1'b0, exp_code: 2'b10});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "watchdog");
    end

endmodule
